display_scanner: RTL and testbench
==================================

// Module: display_scanner
// PURPOSE
// Time-multiplexed scan driver for the 8-digit common-anode seven-segment display.
// Latches a 32-bit hex value (8 nibbles) into a shadow register and walks a digit
// index at a prescaled refresh rate. Drives the nibble (num), digit index (sel),
// active-low anode and decimal point that feed the combinational seven_segment decoder.
// PARAMETERS
// CLK_DIV      100_000  clock cycles per digit slot (100 MHz -> 1 kHz digit rate); >= 2
// GUARD_CYCLES 4        anode-off cycles at the start of each slot (anti-ghosting); < CLK_DIV
// PORTS
// clk        in   1   system clock, all logic on rising edge
// reset      in   1   synchronous, active-high reset
// value      in   32  display data; digit k = value[4k+3:4k], digit 0 is rightmost
// load       in   1   1 = copy value, en_mask, dp_mask into shadow registers this cycle
// en_mask    in   8   per-digit enable; 0 = digit always dark
// dp_mask    in   8   per-digit decimal point request
// num        out  4   nibble of the current digit, to the decoder
// sel        out  3   current digit index 0..7
// anode      out  8   active-low digit select; at most one bit low
// dp         out  1   active-low decimal point for the current digit
// tick       out  1   one-cycle pulse on the last cycle of every slot
// BEHAVIOUR
// - Reset values: shadow regs 0, prescaler 0, sel 0, num 0, anode 8'hFF, dp 1, tick 0.
// - Prescaler counts 0..CLK_DIV-1 and wraps; tick=1 when prescaler==CLK_DIV-1.
// - On the tick cycle, sel advances next cycle: 7 wraps to 0. Prescaler and sel only.
// - All outputs are registered. num, anode and dp reflect the sel value and shadow
//   contents of the previous cycle (1-cycle latency from the sel/shadow update).
// - anode = 8'hFF while prescaler < GUARD_CYCLES (guard) or en_mask_s[sel]==0;
//   otherwise anode = ~(8'b1 << sel). During guard, num still shows the new digit.
// - dp = ~dp_mask_s[sel] when the anode is driven; 1 when the anode is dark.
// - load: shadow regs update at the clock edge where load=1; visible on the outputs
//   one cycle later; the scan position is unaffected. load held high: shadow tracks
//   inputs every cycle. load on a tick cycle: both the new data and the new sel apply.
// - Reset mid-scan: next edge returns everything to reset values; the scan
//   restarts at digit 0 with a full guard period.
// - No FSM beyond the prescaler/sel counters; no handshake and no back-pressure.
// CONFIGURATION
// LEADING_ZERO_BLANK_EN defined: any digit k whose nibble and all higher nibbles
//   (k..7) are 0 is dark (anode 8'hFF, dp 1). Digit 0 is never blanked, so the
//   value 0 shows a single "0". This mask is computed from the shadow register, combinationally.
// Not defined: every enabled digit is shown, including leading zeros.
// TESTING
// 1 reset held 3 cycles -> anode=8'hFF, sel=0, num=0, dp=1, tick=0; release -> slot 0
//   with guard.
// 2 CLK_DIV=8, GUARD=2, load value=32'h1234_5678, en=8'hFF -> sel 0..7 = num 8,7,..,1;
//   anode FF for 2 cycles, then ~(1<<sel) for 6 cycles; tick every 8 cycles; sel 7->0.
// 3 en_mask=8'b1111_0101 -> digits 1 and 3 keep anode=FF through the whole slot;
//   dp_mask=8'h01 -> dp=0 only in the driven part of slot 0.
// 4 load 32'hAAAA_AAAA during slot 3, then 32'h5555_5555 on a tick cycle -> num changes the
//   cycle after each load; sel sequence is unaffected.
// 5 reset asserted mid-slot 5 -> next cycle sel=0, anode=FF, prescaler restarts;
//   the shadow value reads back as 0.
// 6 LEADING_ZERO_BLANK_EN, value=32'h0000_0A03 -> digits 7..3 dark, 2..0 show A,0,3;
//   value=0 -> only digit 0 lit showing 0. Macro undefined -> all 8 digits lit.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan driver for an 8-digit common-anode
// seven-segment display. A shadow copy of value/en_mask/dp_mask is scanned one
// digit per CLK_DIV-cycle slot, and the anode stays dark for the first
// GUARD_CYCLES of each slot.
// Optional build macro: LEADING_ZERO_BLANK_EN darkens leading-zero digits
// (digit 0 is never blanked).
module display_scanner #(
  parameter int CLK_DIV      = 100_000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  en_mask,
  input  logic [7:0]  dp_mask,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic [7:0]  anode,
  output logic        dp,
  output logic        tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD = PW'(GUARD_CYCLES);

  logic [31:0]   value_r;
  logic [7:0]    en_mask_r;
  logic [7:0]    dp_mask_r;
  logic [PW-1:0] presc_r;

  logic          last_s;
  logic [PW-1:0] presc_next_s;
  logic [3:0]    nibble_s;
  logic [7:0]    blank_s;
  logic          lit_s;

  // Slot timing, current nibble and whether the current digit may light.
  always_comb begin
    last_s       = (presc_r == LAST);
    presc_next_s = last_s ? {PW{1'b0}} : presc_r + PW'(1);
    nibble_s     = value_r[{sel, 2'b00} +: 4];
    blank_s      = 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < 8; k++) begin
      blank_s[k] = ~|(value_r >> (4 * k));
    end
`else
    blank_s      = 8'h00;
`endif
    lit_s = (presc_r >= GUARD) && en_mask_r[sel] && !blank_s[sel];
  end

  // Prescaler, digit index and end-of-slot pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
      sel     <= 3'd0;
      tick    <= 1'b0;
    end else begin
      presc_r <= presc_next_s;
      tick    <= (presc_next_s == LAST);
      if (last_s) begin
        sel <= sel + 3'd1;
      end else begin
        sel <= sel;
      end
    end
  end

  // Shadow registers: capture display data whenever load is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r   <= 32'h0000_0000;
      en_mask_r <= 8'h00;
      dp_mask_r <= 8'h00;
    end else if (load) begin
      value_r   <= value;
      en_mask_r <= en_mask;
      dp_mask_r <= dp_mask;
    end else begin
      value_r   <= value_r;
      en_mask_r <= en_mask_r;
      dp_mask_r <= dp_mask_r;
    end
  end

  // Registered digit outputs, one cycle behind the scan position and shadow data.
  always_ff @(posedge clk) begin
    if (reset) begin
      num   <= 4'h0;
      anode <= 8'hFF;
      dp    <= 1'b1;
    end else begin
      num   <= nibble_s;
      anode <= lit_s ? ~(8'd1 << sel) : 8'hFF;
      dp    <= lit_s ? ~dp_mask_r[sel] : 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with CLK_DIV=8, GUARD_CYCLES=2.
// The reference model tracks the number of clock edges since reset plus the
// shadow data, and derives slot position and digit from plain arithmetic.
module tb_display_scanner;

  localparam int D = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = 32'h0;
  logic        load = 1'b0;
  logic [7:0]  en_mask = 8'h00;
  logic [7:0]  dp_mask = 8'h00;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic [7:0]  anode;
  logic        dp;
  logic        tick;

  int compared = 0;
  int mismatched = 0;

  // model state: edges since reset and the shadow contents
  int          m = 0;
  logic [31:0] sh_v = 32'h0;
  logic [7:0]  sh_e = 8'h00;
  logic [7:0]  sh_d = 8'h00;

  display_scanner #(.CLK_DIV(D), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .en_mask(en_mask), .dp_mask(dp_mask),
    .num(num), .sel(sel), .anode(anode), .dp(dp), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (m=%0d)", tag, obs, exp_v, m);
    end
  endtask

  function automatic bit lzb_dark(input logic [31:0] v, input int s);
`ifdef LEADING_ZERO_BLANK_EN
    return (s > 0) && ((v >> (4 * s)) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // one clock: drive inputs, advance model, check every output
  task automatic step(input logic r, input logic ld, input logic [31:0] v,
                      input logic [7:0] e, input logic [7:0] d);
    int p, s;
    bit lit;
    logic [3:0] e_num;
    logic [7:0] e_an;
    logic e_dp;
    reset = r; load = ld; value = v; en_mask = e; dp_mask = d;
    @(posedge clk);
    // outputs after this edge come from the state before it
    p = m % D;
    s = (m / D) % 8;
    lit = (p >= G) && sh_e[s] && !lzb_dark(sh_v, s);
    e_num = 4'((sh_v >> (4 * s)) & 32'hF);
    e_an = lit ? ~(8'd1 << s) : 8'hFF;
    e_dp = lit ? ~sh_d[s] : 1'b1;
    if (r) begin
      m = 0; sh_v = 32'h0; sh_e = 8'h00; sh_d = 8'h00;
      e_num = 4'h0; e_an = 8'hFF; e_dp = 1'b1;
    end else begin
      m++;
      if (ld) begin
        sh_v = v; sh_e = e; sh_d = d;
      end
    end
    #1;
    chk("num", {28'h0, num}, {28'h0, e_num});
    chk("sel", {29'h0, sel}, 32'((m / D) % 8));
    chk("anode", {24'h0, anode}, {24'h0, e_an});
    chk("dp", {31'h0, dp}, {31'h0, e_dp});
    chk("tick", {31'h0, tick}, {31'h0, (!r && (m % D) == D - 1)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  initial begin
    int guard;
    // reset held 3 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 8'h00, 8'h00);
    idle(4);

    // full sweep of all digits
    step(1'b0, 1'b1, 32'h1234_5678, 8'hFF, 8'h00);
    idle(70);

    // disabled digits and a decimal point on digit 0
    step(1'b0, 1'b1, 32'h1234_5678, 8'b1111_0101, 8'h01);
    idle(70);

    // load mid slot 3, then on a tick cycle
    guard = 0;
    while (!(((m / D) % 8) == 3 && (m % D) == 3) && guard < 80) begin idle(1); guard++; end
    chk("reach_slot3", 32'(guard < 80), 32'd1);
    step(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hFF, 8'hF0);
    guard = 0;
    while ((m % D) != D - 1 && guard < 10) begin idle(1); guard++; end
    chk("reach_tick", {31'h0, tick}, 32'd1);
    step(1'b0, 1'b1, 32'h5555_5555, 8'hFF, 8'h0F);
    idle(20);

    // reset mid slot 5
    guard = 0;
    while (!(((m / D) % 8) == 5 && (m % D) == 4) && guard < 80) begin idle(1); guard++; end
    chk("reach_slot5", 32'(guard < 80), 32'd1);
    step(1'b1, 1'b0, 32'h0, 8'h00, 8'h00);
    idle(12);

    // leading zeros and an all-zero value
    step(1'b0, 1'b1, 32'h0000_0A03, 8'hFF, 8'h00);
    idle(70);
    step(1'b0, 1'b1, 32'h0000_0000, 8'hFF, 8'hFF);
    idle(70);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
           $urandom >> (4 * $urandom_range(0, 8)),
           8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
